lsu_mem_arbiter: RTL and testbench
==================================

Name: lsu_mem_arbiter

Overview:
- Shares one data-memory port between NUM_LSUS per-lane LSUs of a SIMD core.
- Round-robin grants one outstanding transaction (read or write) at a time.
- Forwards the granted transaction to memory and returns the ack/read data to the granted lane only.
- Sits between the LSU array and the data memory; each LSU sees a private memory interface.

Parameters:
NUM_LSUS, 4, number of requesting LSUs (lanes); power of two, minimum 2
ADDR_WIDTH, 7, memory address width
DATA_WIDTH, 64, memory data width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
lsu_read_valid  input  NUM_LSUS  per-lane read request
lsu_write_valid  input  NUM_LSUS  per-lane write request
lsu_addr  input  NUM_LSUS*ADDR_WIDTH  per-lane address; lane i at [i*ADDR_WIDTH +: ADDR_WIDTH]
lsu_write_data  input  NUM_LSUS*DATA_WIDTH  per-lane write data
lsu_read_ack  output  NUM_LSUS  per-lane read acknowledge
lsu_write_ack  output  NUM_LSUS  per-lane write acknowledge
lsu_read_data  output  NUM_LSUS*DATA_WIDTH  per-lane returned read data
mem_read_valid  output  1  read request to memory
mem_write_valid  output  1  write request to memory
mem_addr  output  ADDR_WIDTH  memory address
mem_write_data  output  DATA_WIDTH  memory write data
mem_read_ack  input  1  memory read complete
mem_write_ack  input  1  memory write complete
mem_read_data  input  DATA_WIDTH  memory read data, valid with mem_read_ack
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, rst=1): all outputs 0; state IDLE; rr_ptr=0; grant register 0.
- All outputs are registered.
- States: IDLE, MEM_READ, MEM_WRITE, RELEASE.
- IDLE:
  - A lane is pending if read_valid|write_valid is set for it.
  - Scan lanes rr_ptr, rr_ptr+1, ... modulo NUM_LSUS; grant the first pending lane.
  - Latch the lane index, address and write data.
  - If the lane's read_valid is set: mem_read_valid<=1, next state MEM_READ. Read wins if both valid bits are set.
  - Otherwise: mem_write_valid<=1 and mem_write_data<=latched data, next state MEM_WRITE.
  - mem_addr<=latched address.
  - No pending lane: stay in IDLE, outputs unchanged.
- MEM_READ:
  - Hold mem_read_valid and mem_addr until mem_read_ack=1.
  - On that edge: mem_read_valid<=0; lsu_read_data[grant]<=mem_read_data; lsu_read_ack[grant]<=1; next state RELEASE.
- MEM_WRITE: same pattern with mem_write_ack, mem_write_valid and lsu_write_ack[grant].
- RELEASE:
  - Hold the ack high until the granted lane's valid bit (the one being serviced) is sampled low.
  - On that edge: ack<=0; rr_ptr<=grant+1 (wraps modulo NUM_LSUS); next state IDLE.
  - The ack is held so that an LSU whose valid is registered is never re-granted for the same request.
  - If the valid never drops, the arbiter stays in RELEASE. This is required, not a bug; the bench must not hang on any other lane.
- Latency:
  - Request sampled in IDLE at edge N gives mem valid high after edge N.
  - mem ack at edge M gives lsu ack high after edge M.
  - Lane valid seen low at edge K gives ack low and IDLE after edge K.
  - Next grant is at edge K+1 at the earliest.
- Boundaries:
  - mem_read_ack or mem_write_ack outside the matching wait state is ignored.
  - A mem ack of the wrong type in a wait state is ignored.
  - Requests arriving in non-IDLE states wait; the arbiter does not queue beyond the valid levels themselves.
  - A lane withdrawing valid while in MEM_READ or MEM_WRITE does not abort the memory transaction; the result is still delivered, and RELEASE completes at once.
  - lsu_read_data lanes hold their last value until overwritten.
  - lsu_addr and lsu_write_data changing after grant have no effect.
  - Reset mid-transaction drops all valids and acks immediately; memory must tolerate a withdrawn request.
- Fairness: a pending lane is granted within NUM_LSUS-1 other grants.

Decomposition:
- Shared package / common_defs: state encodings ARB_IDLE, ARB_MEM_READ, ARB_MEM_WRITE, ARB_RELEASE (2-bit).
- One sub-module rr_picker: combinational round-robin priority encoder.
  - Inputs: pending mask and rr_ptr.
  - Outputs: grant index and grant_valid.
  - Reused later for an instruction-fetch arbiter.

Test Plan:
- Single read, lane 2 addr 0x15, mem returns 0xDEADBEEF after 3 cycles → mem_addr=0x15, mem_read_valid high for 3+ cycles, lsu_read_data lane2=0xDEADBEEF, only lsu_read_ack[2] pulses, rr_ptr=3.
- All 4 lanes read simultaneously, rr_ptr=0 → grants in order 0,1,2,3; each lane gets its own data; exactly one mem transaction at a time.
- Lane 1 write addr 0x7F data 0x1234 while lane 0 reads addr 0x01, rr_ptr=1 → write serviced first (mem_write_data=0x1234), then read.
- Lane 3 holds valid for 5 cycles after ack → arbiter stays in RELEASE with ack high; lane 0 request is not granted until lane 3 drops valid.
- Assert rst while in MEM_READ → all outputs 0 immediately (asynchronous); a late mem_read_ack after reset is ignored; state is IDLE.
- Spurious mem_write_ack in MEM_READ, and mem_read_ack in IDLE → no state change, no lsu ack.

Source files
------------

// File: rtl/lsu_mem_arbiter_pkg.sv
// Shared definitions for the LSU data-memory arbiter: FSM state encodings
// and a small helper for sizing lane-index fields.
package lsu_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE      = 2'd0,
      ARB_MEM_READ  = 2'd1,
      ARB_MEM_WRITE = 2'd2,
      ARB_RELEASE   = 2'd3
   } arb_state_e;

   localparam int DEF_NUM_LSUS   = 4;
   localparam int DEF_ADDR_WIDTH = 7;
   localparam int DEF_DATA_WIDTH = 64;

   // Width of an index able to name any of n requesters (at least one bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lsu_mem_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: starting at rr_ptr and
// walking upward with wrap-around, returns the first pending requester.
// Kept generic so other arbiters (e.g. instruction fetch) can reuse it.
module lsu_mem_arbiter_rr_picker
   import lsu_mem_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IW      = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] pending,
   input  logic [IW-1:0]      rr_ptr,
   output logic [IW-1:0]      grant,
   output logic               grant_valid
);

   logic [IW-1:0] cand;

   // Scan rr_ptr, rr_ptr+1, ... (NUM_REQ is a power of two, so the index wraps naturally).
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      cand        = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = rr_ptr + IW'(i);
         if (!grant_valid && pending[cand]) begin
            grant       = cand;
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Shares one data-memory port between NUM_LSUS per-lane LSUs. One
// transaction is outstanding at a time; lanes are granted round-robin and
// the ack is held until the granted lane withdraws its request so a lane
// with a registered valid is never serviced twice for one request.
module lsu_mem_arbiter
   import lsu_mem_arbiter_pkg::*;
#(
   parameter int NUM_LSUS   = DEF_NUM_LSUS,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_LSUS-1:0]            lsu_read_valid,
   input  logic [NUM_LSUS-1:0]            lsu_write_valid,
   input  logic [NUM_LSUS*ADDR_WIDTH-1:0] lsu_addr,
   input  logic [NUM_LSUS*DATA_WIDTH-1:0] lsu_write_data,
   output logic [NUM_LSUS-1:0]            lsu_read_ack,
   output logic [NUM_LSUS-1:0]            lsu_write_ack,
   output logic [NUM_LSUS*DATA_WIDTH-1:0] lsu_read_data,
   output logic                           mem_read_valid,
   output logic                           mem_write_valid,
   output logic [ADDR_WIDTH-1:0]          mem_addr,
   output logic [DATA_WIDTH-1:0]          mem_write_data,
   input  logic                           mem_read_ack,
   input  logic                           mem_write_ack,
   input  logic [DATA_WIDTH-1:0]          mem_read_data,
   output logic                           busy
);

   localparam int IW = idx_width(NUM_LSUS);

   arb_state_e                   state, state_next;
   logic [IW-1:0]                rr_ptr, rr_ptr_next;
   logic [IW-1:0]                grant, grant_next;
   logic                         svc_read, svc_read_next;
   logic                         mem_read_valid_next;
   logic                         mem_write_valid_next;
   logic [ADDR_WIDTH-1:0]        mem_addr_next;
   logic [DATA_WIDTH-1:0]        mem_write_data_next;
   logic [NUM_LSUS-1:0]          lsu_read_ack_next;
   logic [NUM_LSUS-1:0]          lsu_write_ack_next;
   logic [NUM_LSUS*DATA_WIDTH-1:0] lsu_read_data_next;
   logic                         busy_next;

   logic [NUM_LSUS-1:0]          pending;
   logic [IW-1:0]                pick;
   logic                         pick_valid;
   logic                         release_done;

   assign pending = lsu_read_valid | lsu_write_valid;

   lsu_mem_arbiter_rr_picker #(
      .NUM_REQ (NUM_LSUS),
      .IW      (IW)
   ) u_picker (
      .pending     (pending),
      .rr_ptr      (rr_ptr),
      .grant       (pick),
      .grant_valid (pick_valid)
   );

   // The lane is released once the valid bit of the kind being serviced drops.
   assign release_done = svc_read ? !lsu_read_valid[grant] : !lsu_write_valid[grant];

   // Next-state and next-output logic; every output is registered from these.
   always_comb begin
      state_next           = state;
      rr_ptr_next          = rr_ptr;
      grant_next           = grant;
      svc_read_next        = svc_read;
      mem_read_valid_next  = mem_read_valid;
      mem_write_valid_next = mem_write_valid;
      mem_addr_next        = mem_addr;
      mem_write_data_next  = mem_write_data;
      lsu_read_ack_next    = lsu_read_ack;
      lsu_write_ack_next   = lsu_write_ack;
      lsu_read_data_next   = lsu_read_data;

      case (state)
         ARB_IDLE: begin
            if (pick_valid) begin
               grant_next    = pick;
               mem_addr_next = lsu_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
               if (lsu_read_valid[pick]) begin
                  svc_read_next       = 1'b1;
                  mem_read_valid_next = 1'b1;
                  state_next          = ARB_MEM_READ;
               end else begin
                  svc_read_next        = 1'b0;
                  mem_write_valid_next = 1'b1;
                  mem_write_data_next  = lsu_write_data[pick*DATA_WIDTH +: DATA_WIDTH];
                  state_next           = ARB_MEM_WRITE;
               end
            end
         end
         ARB_MEM_READ: begin
            if (mem_read_ack) begin
               mem_read_valid_next = 1'b0;
               lsu_read_data_next[grant*DATA_WIDTH +: DATA_WIDTH] = mem_read_data;
               lsu_read_ack_next[grant] = 1'b1;
               state_next = ARB_RELEASE;
            end
         end
         ARB_MEM_WRITE: begin
            if (mem_write_ack) begin
               mem_write_valid_next      = 1'b0;
               lsu_write_ack_next[grant] = 1'b1;
               state_next                = ARB_RELEASE;
            end
         end
         ARB_RELEASE: begin
            if (release_done) begin
               lsu_read_ack_next  = '0;
               lsu_write_ack_next = '0;
               rr_ptr_next        = grant + IW'(1);
               state_next         = ARB_IDLE;
            end
         end
         default: begin
            state_next = ARB_IDLE;
         end
      endcase

      busy_next = (state_next != ARB_IDLE);
   end

   // State and output registers, cleared asynchronously so a reset withdraws everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= ARB_IDLE;
         rr_ptr          <= '0;
         grant           <= '0;
         svc_read        <= 1'b0;
         mem_read_valid  <= 1'b0;
         mem_write_valid <= 1'b0;
         mem_addr        <= '0;
         mem_write_data  <= '0;
         lsu_read_ack    <= '0;
         lsu_write_ack   <= '0;
         lsu_read_data   <= '0;
         busy            <= 1'b0;
      end else begin
         state           <= state_next;
         rr_ptr          <= rr_ptr_next;
         grant           <= grant_next;
         svc_read        <= svc_read_next;
         mem_read_valid  <= mem_read_valid_next;
         mem_write_valid <= mem_write_valid_next;
         mem_addr        <= mem_addr_next;
         mem_write_data  <= mem_write_data_next;
         lsu_read_ack    <= lsu_read_ack_next;
         lsu_write_ack   <= lsu_write_ack_next;
         lsu_read_data   <= lsu_read_data_next;
         busy            <= busy_next;
      end
   end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Testbench for lsu_mem_arbiter: directed requests push expected memory
// transactions and expected lane acks into queues; a memory responder and
// an ack monitor pop and compare as the DUT presents them.
module tb_lsu_mem_arbiter;

   localparam int N  = 4;
   localparam int AW = 7;
   localparam int DW = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [N-1:0]    lsu_read_valid  = '0;
   logic [N-1:0]    lsu_write_valid = '0;
   logic [N*AW-1:0] lsu_addr        = '0;
   logic [N*DW-1:0] lsu_write_data  = '0;
   logic [N-1:0]    lsu_read_ack;
   logic [N-1:0]    lsu_write_ack;
   logic [N*DW-1:0] lsu_read_data;
   logic            mem_read_valid;
   logic            mem_write_valid;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_write_data;
   logic            mem_read_ack;
   logic            mem_write_ack;
   logic [DW-1:0]   mem_read_data;
   logic            busy;

   typedef struct {
      int            lane;
      bit            is_read;
      logic [DW-1:0] data;
   } lsu_exp_t;

   typedef struct {
      bit            is_write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } mem_exp_t;

   lsu_exp_t lsu_q[$];
   mem_exp_t mem_q[$];

   int total = 0;
   int bad   = 0;

   // memory model state
   logic [DW-1:0] rom [0:127];
   int            mem_delay   = 1;
   int            cnt         = 0;
   logic          prev_mv     = 1'b0;
   logic          model_rack  = 1'b0;
   logic          model_wack  = 1'b0;
   logic [DW-1:0] model_rdata = '0;
   logic          inj_rack    = 1'b0;
   logic          inj_wack    = 1'b0;
   logic [DW-1:0] inj_data    = '0;

   assign mem_read_ack  = model_rack | inj_rack;
   assign mem_write_ack = model_wack | inj_wack;
   assign mem_read_data = inj_rack ? inj_data : model_rdata;

   lsu_mem_arbiter #(
      .NUM_LSUS   (N),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .lsu_read_valid  (lsu_read_valid),
      .lsu_write_valid (lsu_write_valid),
      .lsu_addr        (lsu_addr),
      .lsu_write_data  (lsu_write_data),
      .lsu_read_ack    (lsu_read_ack),
      .lsu_write_ack   (lsu_write_ack),
      .lsu_read_data   (lsu_read_data),
      .mem_read_valid  (mem_read_valid),
      .mem_write_valid (mem_write_valid),
      .mem_addr        (mem_addr),
      .mem_write_data  (mem_write_data),
      .mem_read_ack    (mem_read_ack),
      .mem_write_ack   (mem_write_ack),
      .mem_read_data   (mem_read_data),
      .busy            (busy)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
      total++;
      if (actual !== required) begin
         bad++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
      end
   endtask

   task automatic expectLsu(input int lane, input bit is_read, input logic [DW-1:0] data);
      lsu_exp_t e;
      e.lane = lane; e.is_read = is_read; e.data = data;
      lsu_q.push_back(e);
   endtask

   task automatic expectMem(input bit is_write, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      mem_exp_t e;
      e.is_write = is_write; e.addr = addr; e.wdata = wdata;
      mem_q.push_back(e);
   endtask

   task automatic applyStimulus(input int lane, input bit rd, input bit wr,
                                input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      lsu_read_valid[lane]         = rd;
      lsu_write_valid[lane]        = wr;
      lsu_addr[lane*AW +: AW]      = addr;
      lsu_write_data[lane*DW +: DW] = wdata;
   endtask

   // Behaves like the LSUs: a lane drops its request once it sees its ack.
   task automatic waitUntilIdle(input string name, input int budget);
      int n = 0;
      bit done = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
         for (int i = 0; i < N; i++) begin
            if ((lsu_read_ack[i] || lsu_write_ack[i]) && (lsu_read_valid[i] || lsu_write_valid[i])) begin
               lsu_read_valid[i]  = 1'b0;
               lsu_write_valid[i] = 1'b0;
            end
         end
         if (lsu_read_valid == '0 && lsu_write_valid == '0 && !busy) done = 1;
      end
      checkOutput({name, "_idle"}, 64'(done), 64'd1);
   endtask

   task automatic waitMemValid(input string name, input int budget);
      int n = 0;
      while (!(mem_read_valid || mem_write_valid) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_memvalid"}, 64'(mem_read_valid || mem_write_valid), 64'd1);
   endtask

   // Memory responder: checks each new request against the expected queue
   // and acks it mem_delay cycles later with data from the ROM table.
   always @(negedge clk) begin
      mem_exp_t m;
      model_rack = 1'b0;
      model_wack = 1'b0;
      if (mem_read_valid || mem_write_valid) begin
         if (!prev_mv) begin
            checkOutput("mem_one_op", 64'(mem_read_valid & mem_write_valid), 64'd0);
            if (mem_q.size() == 0) begin
               total++; bad++;
               $display("[TB] FAIL mem_unexpected: actual addr=%h required no request", mem_addr);
            end else begin
               m = mem_q.pop_front();
               checkOutput("mem_is_write", 64'(mem_write_valid), 64'(m.is_write));
               checkOutput("mem_addr", 64'(mem_addr), 64'(m.addr));
               if (m.is_write) checkOutput("mem_wdata", mem_write_data, m.wdata);
            end
         end
         if (cnt >= mem_delay) begin
            model_rack  = mem_read_valid;
            model_wack  = mem_write_valid && !mem_read_valid;
            model_rdata = rom[mem_addr];
            cnt = 0;
         end else begin
            cnt++;
         end
      end else begin
         cnt = 0;
      end
      prev_mv = mem_read_valid || mem_write_valid;
   end

   // Ack monitor: every rising lane ack must match the next expected response.
   logic [N-1:0] prev_ra = '0;
   logic [N-1:0] prev_wa = '0;
   always @(negedge clk) begin
      lsu_exp_t e;
      for (int i = 0; i < N; i++) begin
         if ((lsu_read_ack[i] && !prev_ra[i]) || (lsu_write_ack[i] && !prev_wa[i])) begin
            if (lsu_q.size() == 0) begin
               total++; bad++;
               $display("[TB] FAIL ack_unexpected: actual lane=%0d required none", i);
            end else begin
               e = lsu_q.pop_front();
               checkOutput("ack_lane", 64'(i), 64'(e.lane));
               checkOutput("ack_type", {62'd0, lsu_read_ack[i], lsu_write_ack[i]},
                           e.is_read ? 64'd2 : 64'd1);
               if (e.is_read) checkOutput("read_data", lsu_read_data[i*DW +: DW], e.data);
            end
            checkOutput("ack_onehot", 64'($countones(lsu_read_ack | lsu_write_ack)), 64'd1);
         end
      end
      prev_ra = lsu_read_ack;
      prev_wa = lsu_write_ack;
   end

   // Global guard so the bench can never hang.
   initial begin
      repeat (20000) @(posedge clk);
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus sequence.
   initial begin
      int n;
      for (int a = 0; a < 128; a++) rom[a] = {32'hA5A5_0000 | 32'(a), 32'h0000_1000 | 32'(a)};
      rom[7'h15] = 64'h0000_0000_DEAD_BEEF;

      // reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_mem_rv", 64'(mem_read_valid), 64'd0);
      checkOutput("rst_mem_wv", 64'(mem_write_valid), 64'd0);
      checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
      checkOutput("rst_mem_wdata", mem_write_data, 64'd0);
      checkOutput("rst_rack", 64'(lsu_read_ack), 64'd0);
      checkOutput("rst_wack", 64'(lsu_write_ack), 64'd0);
      checkOutput("rst_rdata", 64'(|lsu_read_data), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // single read, lane 2, memory answers after 3 cycles
      mem_delay = 3;
      applyStimulus(2, 1, 0, 7'h15, '0);
      expectMem(0, 7'h15, '0);
      expectLsu(2, 1, 64'h0000_0000_DEAD_BEEF);
      waitMemValid("t1", 10);
      n = 0;
      while (mem_read_valid && n < 20) begin
         n++;
         @(negedge clk);
      end
      checkOutput("t1_rv_cycles", 64'(n >= 3), 64'd1);
      waitUntilIdle("t1", 20);

      // lanes 0 and 3 together after lane 2: lane 3 first
      mem_delay = 1;
      applyStimulus(0, 1, 0, 7'h20, '0);
      applyStimulus(3, 1, 0, 7'h23, '0);
      expectMem(0, 7'h23, '0);
      expectLsu(3, 1, 64'hA5A5_0023_0000_1023);
      expectMem(0, 7'h20, '0);
      expectLsu(0, 1, 64'hA5A5_0020_0000_1020);
      waitUntilIdle("t2", 40);

      // lane 1 write vs lane 0 read with pointer at 1: write first
      applyStimulus(0, 1, 0, 7'h01, '0);
      applyStimulus(1, 0, 1, 7'h7F, 64'h1234);
      expectMem(1, 7'h7F, 64'h1234);
      expectLsu(1, 0, '0);
      expectMem(0, 7'h01, '0);
      expectLsu(0, 1, 64'hA5A5_0001_0000_1001);
      waitUntilIdle("t3", 40);

      // lane 3 write brings the pointer back to 0
      applyStimulus(3, 0, 1, 7'h70, 64'hABCD);
      expectMem(1, 7'h70, 64'hABCD);
      expectLsu(3, 0, '0);
      waitUntilIdle("t4", 20);

      // all four lanes read at once: 0,1,2,3
      for (int i = 0; i < N; i++) begin
         applyStimulus(i, 1, 0, 7'(8 + i), '0);
      end
      expectMem(0, 7'h08, '0); expectLsu(0, 1, 64'hA5A5_0008_0000_1008);
      expectMem(0, 7'h09, '0); expectLsu(1, 1, 64'hA5A5_0009_0000_1009);
      expectMem(0, 7'h0A, '0); expectLsu(2, 1, 64'hA5A5_000A_0000_100A);
      expectMem(0, 7'h0B, '0); expectLsu(3, 1, 64'hA5A5_000B_0000_100B);
      waitUntilIdle("t5", 80);

      // lane 3 holds valid after its ack; lane 0 must wait
      mem_delay = 2;
      applyStimulus(3, 1, 0, 7'h33, '0);
      expectMem(0, 7'h33, '0);
      expectLsu(3, 1, 64'hA5A5_0033_0000_1033);
      expectMem(0, 7'h40, '0);
      expectLsu(0, 1, 64'hA5A5_0040_0000_1040);
      n = 0;
      while (!lsu_read_ack[3] && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t6_ack3", 64'(lsu_read_ack[3]), 64'd1);
      applyStimulus(0, 1, 0, 7'h40, '0);
      repeat (5) begin
         @(negedge clk);
         checkOutput("t6_hold_ack", 64'(lsu_read_ack[3]), 64'd1);
         checkOutput("t6_no_grant", 64'(mem_read_valid | mem_write_valid), 64'd0);
         checkOutput("t6_busy", 64'(busy), 64'd1);
      end
      lsu_read_valid[3] = 1'b0;
      waitUntilIdle("t6", 40);

      // spurious write ack during a read, then a read ack while idle
      mem_delay = 6;
      applyStimulus(1, 1, 0, 7'h11, '0);
      expectMem(0, 7'h11, '0);
      expectLsu(1, 1, 64'hA5A5_0011_0000_1011);
      waitMemValid("t7", 10);
      inj_wack = 1'b1;
      @(negedge clk);
      inj_wack = 1'b0;
      checkOutput("t7_still_rv", 64'(mem_read_valid), 64'd1);
      checkOutput("t7_no_rack", 64'(lsu_read_ack), 64'd0);
      checkOutput("t7_no_wack", 64'(lsu_write_ack), 64'd0);
      waitUntilIdle("t7", 40);
      inj_data = 64'hFFFF_FFFF_FFFF_FFFF;
      inj_rack = 1'b1;
      @(negedge clk);
      inj_rack = 1'b0;
      checkOutput("t7_idle_busy", 64'(busy), 64'd0);
      checkOutput("t7_idle_rack", 64'(lsu_read_ack), 64'd0);
      checkOutput("t7_idle_rv", 64'(mem_read_valid), 64'd0);
      checkOutput("t7_idle_data", lsu_read_data[1*DW +: DW], 64'hA5A5_0011_0000_1011);

      // lane 2 withdraws mid-write and changes its address/data
      mem_delay = 4;
      applyStimulus(2, 0, 1, 7'h05, 64'h55AA);
      expectMem(1, 7'h05, 64'h55AA);
      expectLsu(2, 0, '0);
      waitMemValid("t8", 10);
      applyStimulus(2, 0, 0, 7'h66, 64'h9999);
      @(negedge clk);
      checkOutput("t8_addr_hold", 64'(mem_addr), 64'h05);
      checkOutput("t8_wdata_hold", mem_write_data, 64'h55AA);
      checkOutput("t8_wv_hold", 64'(mem_write_valid), 64'd1);
      waitUntilIdle("t8", 30);

      // read and write both set on one lane: read wins
      mem_delay = 1;
      applyStimulus(2, 1, 1, 7'h12, 64'h7777);
      expectMem(0, 7'h12, '0);
      expectLsu(2, 1, 64'hA5A5_0012_0000_1012);
      waitUntilIdle("t9", 20);

      // asynchronous reset in the middle of a read
      mem_delay = 8;
      applyStimulus(2, 1, 0, 7'h22, '0);
      expectMem(0, 7'h22, '0);
      waitMemValid("t10", 10);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t10_rv", 64'(mem_read_valid), 64'd0);
      checkOutput("t10_busy", 64'(busy), 64'd0);
      checkOutput("t10_addr", 64'(mem_addr), 64'd0);
      checkOutput("t10_rdata", 64'(|lsu_read_data), 64'd0);
      lsu_read_valid = '0;
      lsu_write_valid = '0;
      @(negedge clk);
      rst = 1'b0;
      inj_data = 64'h0BAD_0BAD_0BAD_0BAD;
      inj_rack = 1'b1;
      @(negedge clk);
      inj_rack = 1'b0;
      checkOutput("t10_late_busy", 64'(busy), 64'd0);
      checkOutput("t10_late_rack", 64'(lsu_read_ack), 64'd0);
      checkOutput("t10_late_data", lsu_read_data[2*DW +: DW], 64'd0);

      // pointer is back at 0 after reset: lane 1 before lane 3
      mem_delay = 1;
      applyStimulus(1, 1, 0, 7'h09, '0);
      applyStimulus(3, 1, 0, 7'h0B, '0);
      expectMem(0, 7'h09, '0); expectLsu(1, 1, 64'hA5A5_0009_0000_1009);
      expectMem(0, 7'h0B, '0); expectLsu(3, 1, 64'hA5A5_000B_0000_100B);
      waitUntilIdle("t11", 40);

      repeat (2) @(negedge clk);
      checkOutput("lsu_q_empty", 64'(lsu_q.size()), 64'd0);
      checkOutput("mem_q_empty", 64'(mem_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
